// File: rtl/mac_pkg.sv
// Shared constants and overflow-mode type for the pipelined MAC.
package mac_pkg;
  localparam int DEF_WIDTH       = 14;
  localparam int DEF_ACC_WIDTH   = 28;
  localparam int DEF_PIPE_STAGES = 4;

  typedef enum logic {
    WRAP = 1'b0,
    SAT  = 1'b1
  } ovf_mode_e;
endpackage

// File: rtl/pipe_mult.sv
// Signed multiplier: one operand register then PIPE_STAGES product registers,
// with valid/clear sideband bits travelling alongside; never stalls.
module pipe_mult
  import mac_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int PIPE_STAGES = DEF_PIPE_STAGES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  input  logic                      valid_in,
  input  logic                      clear_in,
  output logic signed [2*WIDTH-1:0] p,
  output logic                      valid_out,
  output logic                      clear_out
);
  localparam int PW = 2 * WIDTH;

  logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic                    in_vld_q, in_vld_d, in_clr_q, in_clr_d;
  logic signed [PW-1:0]    prod_q [PIPE_STAGES];
  logic signed [PW-1:0]    prod_d [PIPE_STAGES];
  logic [PIPE_STAGES-1:0]  vld_q, vld_d, clr_q, clr_d;

  always_comb begin
    a_d      = a;
    b_d      = b;
    in_vld_d = valid_in;
    // a clear without valid must never reach the accumulator
    in_clr_d = valid_in & clear_in;
    prod_d[0] = PW'(a_q) * PW'(b_q);
    vld_d[0]  = in_vld_q;
    clr_d[0]  = in_clr_q;
    for (int i = 1; i < PIPE_STAGES; i++) begin
      prod_d[i] = prod_q[i-1];
      vld_d[i]  = vld_q[i-1];
      clr_d[i]  = clr_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      in_vld_q <= 1'b0;
      in_clr_q <= 1'b0;
      vld_q    <= '0;
      clr_q    <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) prod_q[i] <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      in_vld_q <= in_vld_d;
      in_clr_q <= in_clr_d;
      vld_q    <= vld_d;
      clr_q    <= clr_d;
      for (int i = 0; i < PIPE_STAGES; i++) prod_q[i] <= prod_d[i];
    end
  end

  assign p         = prod_q[PIPE_STAGES-1];
  assign valid_out = vld_q[PIPE_STAGES-1];
  assign clear_out = clr_q[PIPE_STAGES-1];
endmodule

// File: rtl/param_pipe_mac.sv
// Pipelined signed multiply-accumulate, latency PIPE_STAGES+1, full throughput,
// wrap or clamp on overflow with a sticky overflow flag cleared by a clear sample.
module param_pipe_mac
  import mac_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int PIPE_STAGES = DEF_PIPE_STAGES,
  parameter int SATURATE    = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [WIDTH-1:0]     a,
  input  logic signed [WIDTH-1:0]     b,
  input  logic                        valid_in,
  input  logic                        clear_in,
  output logic signed [ACC_WIDTH-1:0] f,
  output logic                        valid_out,
  output logic                        overflow
);
  localparam int        AW1  = ACC_WIDTH + 1;
  localparam ovf_mode_e MODE = (SATURATE != 0) ? SAT : WRAP;

  if (ACC_WIDTH < 2 * WIDTH) begin : g_bad_acc_width
    $error("param_pipe_mac: ACC_WIDTH must be >= 2*WIDTH");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 8) begin : g_bad_pipe_stages
    $error("param_pipe_mac: PIPE_STAGES must be in 1..8");
  end

  logic signed [2*WIDTH-1:0]   prod;
  logic                        ret_vld, ret_clr;
  logic signed [ACC_WIDTH-1:0] f_q, f_d;
  logic                        vo_q, vo_d, ovf_q, ovf_d;
  logic signed [ACC_WIDTH:0]   sum;
  logic                        sum_ovf;

  pipe_mult #(
    .WIDTH       (WIDTH),
    .PIPE_STAGES (PIPE_STAGES)
  ) u_pipe_mult (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .valid_in  (valid_in),
    .clear_in  (clear_in),
    .p         (prod),
    .valid_out (ret_vld),
    .clear_out (ret_clr)
  );

  always_comb begin
    f_d     = f_q;
    vo_d    = ret_vld;
    ovf_d   = ovf_q;
    sum     = '0;
    sum_ovf = 1'b0;
    if (ret_vld) begin
      sum     = ret_clr ? AW1'(prod) : AW1'(f_q) + AW1'(prod);
      // top two bits disagree when the sum does not fit in ACC_WIDTH bits
      sum_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
      if (sum_ovf && MODE == SAT) begin
        f_d = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                             : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
        f_d = sum[ACC_WIDTH-1:0];
      end
      ovf_d = (ret_clr ? 1'b0 : ovf_q) | sum_ovf;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_q   <= '0;
      vo_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      f_q   <= f_d;
      vo_q  <= vo_d;
      ovf_q <= ovf_d;
    end
  end

  assign f         = f_q;
  assign valid_out = vo_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_param_pipe_mac.sv
// Four MAC builds (wrap, saturate, 1-stage, 8-stage) on a shared input stream,
// compared every cycle against a cycle-indexed sample log model, plus directed values.
module tb_param_pipe_mac;
  localparam int     NI   = 4;
  localparam int     LOGN = 4096;
  localparam int     LAT  [NI] = '{4, 4, 1, 8};
  localparam bit     SATM [NI] = '{1'b0, 1'b1, 1'b0, 1'b0};
  localparam longint AMAX = (longint'(1) << 27) - 1;
  localparam longint AMIN = -(longint'(1) << 27);
  localparam longint AMOD = longint'(1) << 28;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [13:0] a, b;
  logic               valid_in, clear_in;
  logic signed [27:0] f_o  [NI];
  logic               vo_o [NI];
  logic               ovf_o[NI];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int rst_cyc  = 0;

  bit     log_v [LOGN];
  bit     log_c [LOGN];
  longint log_p [LOGN];
  longint mf [NI];
  bit     mo [NI];
  bit     mv [NI];

  always #5 clk = ~clk;

  param_pipe_mac #(.SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_in(clear_in),
    .f(f_o[0]), .valid_out(vo_o[0]), .overflow(ovf_o[0]));
  param_pipe_mac #(.SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_in(clear_in),
    .f(f_o[1]), .valid_out(vo_o[1]), .overflow(ovf_o[1]));
  param_pipe_mac #(.PIPE_STAGES(1)) u_p1 (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_in(clear_in),
    .f(f_o[2]), .valid_out(vo_o[2]), .overflow(ovf_o[2]));
  param_pipe_mac #(.PIPE_STAGES(8)) u_p8 (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_in(clear_in),
    .f(f_o[3]), .valid_out(vo_o[3]), .overflow(ovf_o[3]));

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected state at edge cyc: the sample logged PIPE_STAGES+1 edges earlier retires,
  // unless a reset edge fell between its acceptance and now.
  function automatic void model_step(input int k);
    int     m;
    longint s;
    bit     o;
    mv[k] = 1'b0;
    if (reset) begin
      mf[k] = 0;
      mo[k] = 1'b0;
    end else begin
      m = cyc - LAT[k] - 1;
      if (m >= 1 && m < LOGN && m > rst_cyc && log_v[m]) begin
        s = (log_c[m] ? 64'sd0 : mf[k]) + log_p[m];
        o = (s > AMAX) || (s < AMIN);
        if (o) begin
          if (SATM[k]) s = (s > 0) ? AMAX : AMIN;
          else         s = (s > AMAX) ? s - AMOD : s + AMOD;
        end
        mf[k] = s;
        mo[k] = (log_c[m] ? 1'b0 : mo[k]) | o;
        mv[k] = 1'b1;
      end
    end
  endfunction

  initial begin
    for (int k = 0; k < NI; k++) begin
      mf[k] = 0; mo[k] = 1'b0; mv[k] = 1'b0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      if (cyc < LOGN) begin
        log_v[cyc] = valid_in;
        log_c[cyc] = clear_in;
        log_p[cyc] = longint'(a) * longint'(b);
      end
      if (reset) rst_cyc = cyc;
      for (int k = 0; k < NI; k++) model_step(k);
      #1;
      for (int k = 0; k < NI; k++) begin
        check($sformatf("mdl_f%0d", k),   longint'(f_o[k]), mf[k]);
        check($sformatf("mdl_vo%0d", k),  longint'(vo_o[k]), longint'(mv[k]));
        check($sformatf("mdl_ovf%0d", k), longint'(ovf_o[k]), longint'(mo[k]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Drive one input set after a falling edge; t_acc is the rising edge that samples it.
  task automatic send(input bit v, input bit c, input logic signed [13:0] aa,
                      input logic signed [13:0] bb, output int t_acc);
    @(negedge clk);
    valid_in = v;
    clear_in = c;
    a        = aa;
    b        = bb;
    t_acc    = cyc + 1;
  endtask

  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc < n && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (cyc < n) check("wait_timeout", cyc, n);
  endtask

  initial begin
    int t1, tx;
    logic signed [13:0] ra, rb;
    reset = 1'b1; valid_in = 1'b0; clear_in = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_f", f_o[0], 0);
    check("rst_vo", vo_o[0], 0);
    check("rst_ovf", ovf_o[0], 0);
    reset = 1'b0;

    // two-term sum, fixed latency
    send(1, 1, 3, -4, t1);
    send(1, 0, 5, 6, tx);
    send(0, 0, 0, 0, tx);
    wait_cyc(t1 + 4); check("lat_vo_early", vo_o[0], 0);
    wait_cyc(t1 + 5); check("lat_f1", f_o[0], -12); check("lat_vo1", vo_o[0], 1);
    wait_cyc(t1 + 6); check("lat_f2", f_o[0], 18);  check("lat_vo2", vo_o[0], 1);
    wait_cyc(t1 + 7); check("lat_vo_late", vo_o[0], 0); check("lat_hold", f_o[0], 18);

    // overflow in wrap and clamp modes, then a clear restarts
    send(1, 1, 8191, 8191, t1);
    send(1, 0, 8191, 8191, tx);
    send(1, 0, 8191, 8191, tx);
    send(1, 1, 2, 2, tx);
    send(0, 0, 0, 0, tx);
    wait_cyc(t1 + 5); check("wrap_f1", f_o[0], 67092481);  check("wrap_o1", ovf_o[0], 0);
    wait_cyc(t1 + 6); check("wrap_f2", f_o[0], 134184962); check("wrap_o2", ovf_o[0], 0);
    wait_cyc(t1 + 7); check("wrap_f3", f_o[0], -67158013); check("wrap_o3", ovf_o[0], 1);
    check("sat_f3", f_o[1], 134217727); check("sat_o3", ovf_o[1], 1);
    wait_cyc(t1 + 8); check("sat_f4", f_o[1], 4); check("sat_o4", ovf_o[1], 0);
    check("wrap_f4", f_o[0], 4); check("wrap_o4", ovf_o[0], 0);

    // most-negative operands, then clear_in without valid is ignored
    send(1, 1, -8192, -8192, t1);
    send(0, 0, 0, 0, tx);
    wait_cyc(t1 + 5);
    check("neg_f", f_o[0], 67108864); check("neg_ovf", ovf_o[0], 0);
    check("neg_f_sat", f_o[1], 67108864);
    for (int i = 0; i < 10; i++) begin
      ra = 14'($urandom); rb = 14'($urandom);
      send(0, 1, ra, rb, tx);
      check("noval_vo", vo_o[0], 0);
    end
    send(0, 0, 0, 0, tx);
    check("noval_f", f_o[0], 67108864);
    check("noval_ovf", ovf_o[0], 0);

    // reset with samples in flight
    send(1, 0, 100, 100, tx);
    send(1, 0, -200, 50, tx);
    send(1, 1, 7, 7, tx);
    @(negedge clk);
    reset = 1'b1; valid_in = 1'b0; clear_in = 1'b0;
    #1;
    check("arst_f", f_o[0], 0);
    check("arst_vo", vo_o[0], 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send(0, 0, 0, 0, tx);
      check("drop_vo", vo_o[0], 0);
      check("drop_vo8", vo_o[3], 0);
    end
    send(1, 0, 1, 1, t1);
    send(0, 0, 0, 0, tx);
    wait_cyc(t1 + 4); check("post_rst_f0", f_o[0], 0);
    wait_cyc(t1 + 5); check("post_rst_f1", f_o[0], 1); check("post_rst_vo", vo_o[0], 1);

    // random stream, checked every cycle by the model on all four builds
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 7))
        0:       ra = -14'sd8192;
        1:       ra = 14'sd8191;
        default: ra = 14'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       rb = -14'sd8192;
        1:       rb = 14'sd8191;
        default: rb = 14'($urandom);
      endcase
      send($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, ra, rb, tx);
    end
    for (int i = 0; i < 12; i++) send(0, 0, 0, 0, tx);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
